// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-flag bit positions for the ALU.
// The flag vector is packed {N,Z,C,V} from bit 3 down to bit 0.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_JMP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_LSL = 4'h3,
    OP_LSR = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_MOV = 4'hA,
    OP_BEQ = 4'hB,
    OP_BNE = 4'hC,
    OP_BLT = 4'hD,
    OP_BGT = 4'hE,
    OP_CMP = 4'hF
  } opcode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Jumps and branches only read the flags; every other opcode may write them.
  function automatic logic writes_flags(input opcode_e op);
    return !(op inside {OP_JMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGT});
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational zero-fill logical shifter with a carry of the last bit shifted out.
// WIDTH must be a power of two so the in-range amount is the low log2(WIDTH) bits.
module alu_shifter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] amount,
  input  logic             direction,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SW = $clog2(WIDTH);

  logic          over;
  logic [SW-1:0] sh;
  logic [WIDTH:0] ext_l;
  logic [WIDTH:0] ext_r;

  assign over = |amount[WIDTH-1:SW];
  assign sh   = amount[SW-1:0];

  // One spare bit beside the data catches the last bit shifted out; a shift
  // of zero leaves that spare bit at 0, so carry is 0 with no special case.
  assign ext_l = {1'b0, data} << sh;
  assign ext_r = {data, 1'b0} >> sh;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    if (!over) begin
      if (direction) begin
        result = ext_r[WIDTH:1];
        carry  = ext_r[0];
      end else begin
        result = ext_l[WIDTH-1:0];
        carry  = ext_l[WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU: combinational result/flag mux followed by one output register
// stage holding Q and flag_out, cleared asynchronously by rst.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] OP0,
  input  logic [WIDTH-1:0] OP1,
  input  logic             flag_en,
  input  logic [3:0]       flag_in,
  output logic [WIDTH-1:0] Q,
  output logic [3:0]       flag_out
);

  opcode_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_result;
  logic             sh_carry;
  logic             taken;
  logic [WIDTH-1:0] result;
  logic             c_flag;
  logic             v_flag;
  logic [3:0]       flags_next;

  assign op   = opcode_e'(func);
  assign sum  = {1'b0, OP0} + {1'b0, OP1};
  assign diff = {1'b0, OP0} - {1'b0, OP1};

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data      (OP0),
    .amount    (OP1),
    .direction (op == OP_LSR),
    .result    (sh_result),
    .carry     (sh_carry)
  );

  always_comb begin
    unique case (op)
      OP_BEQ:  taken = flag_in[FLAG_Z];
      OP_BNE:  taken = !flag_in[FLAG_Z];
      OP_BLT:  taken = flag_in[FLAG_N] ^ flag_in[FLAG_V];
      OP_BGT:  taken = !flag_in[FLAG_Z] && (flag_in[FLAG_N] == flag_in[FLAG_V]);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    result = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (op)
      OP_JMP: result = OP0;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (OP0[WIDTH-1] == OP1[WIDTH-1]) && (sum[WIDTH-1] != OP0[WIDTH-1]);
      end
      // The extra top bit of the widened difference is the unsigned borrow.
      OP_SUB, OP_CMP: begin
        result = diff[WIDTH-1:0];
        c_flag = diff[WIDTH];
        v_flag = (OP0[WIDTH-1] != OP1[WIDTH-1]) && (diff[WIDTH-1] != OP0[WIDTH-1]);
      end
      OP_LSL, OP_LSR: begin
        result = sh_result;
        c_flag = sh_carry;
      end
      OP_AND:        result = OP0 & OP1;
      OP_OR:         result = OP0 | OP1;
      OP_XOR:        result = OP0 ^ OP1;
      OP_LD, OP_ST:  result = sum[WIDTH-1:0];
      OP_MOV:        result = OP1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT: result = {{(WIDTH-1){1'b0}}, taken};
    endcase
  end

  always_comb begin
    flags_next = flag_in;
    if (flag_en && writes_flags(op)) begin
      flags_next[FLAG_N] = result[WIDTH-1];
      flags_next[FLAG_Z] = (result == '0);
      flags_next[FLAG_C] = c_flag;
      flags_next[FLAG_V] = v_flag;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q        <= '0;
      flag_out <= '0;
    end else begin
      Q        <= result;
      flag_out <= flags_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, randomized vectors against an
// integer-arithmetic reference model, and asynchronous reset behaviour.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  func;
  logic [15:0] OP0;
  logic [15:0] OP1;
  logic        flag_en;
  logic [3:0]  flag_in;
  logic [15:0] Q;
  logic [3:0]  flag_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .func     (func),
    .OP0      (OP0),
    .OP1      (OP1),
    .flag_en  (flag_en),
    .flag_in  (flag_in),
    .Q        (Q),
    .flag_out (flag_out)
  );

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference: returns {Q, flag_out} expected one edge after these inputs.
  function automatic logic [19:0] ref_model(input int f, input int a, input int b,
                                            input bit fen, input logic [3:0] fin);
    int q, s;
    bit c, v, n, z;
    q = 0; c = 0; v = 0;
    case (f)
      0: q = a;
      1: begin
        q = (a + b) % 65536; c = (a + b) > 65535;
        s = sx(a) + sx(b); v = (s > 32767) || (s < -32768);
      end
      2, 15: begin
        q = (a - b + 65536) % 65536; c = a < b;
        s = sx(a) - sx(b); v = (s > 32767) || (s < -32768);
      end
      3: begin
        if (b == 0) q = a;
        else if (b < 16) begin q = (a * (1 << b)) % 65536; c = ((a >> (16 - b)) & 1) == 1; end
      end
      4: begin
        if (b == 0) q = a;
        else if (b < 16) begin q = a >> b; c = ((a >> (b - 1)) & 1) == 1; end
      end
      5: q = a & b;
      6: q = a | b;
      7: q = a ^ b;
      8, 9: q = (a + b) % 65536;
      10: q = b;
      11: q = fin[2] ? 1 : 0;
      12: q = fin[2] ? 0 : 1;
      13: q = (fin[3] != fin[0]) ? 1 : 0;
      default: q = (!fin[2] && (fin[3] == fin[0])) ? 1 : 0;
    endcase
    n = q >= 32768;
    z = q == 0;
    if (fen && (f >= 1) && (f <= 10 || f == 15)) return {q[15:0], n, z, c, v};
    return {q[15:0], fin};
  endfunction

  task automatic check(input string tag, input logic [19:0] expected);
    checks++;
    assert ({Q, flag_out} === expected)
    else begin
      errors++;
      $error("FAIL %s: got Q=%h flags=%b, want Q=%h flags=%b",
             tag, Q, flag_out, expected[19:4], expected[3:0]);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic fen, input logic [3:0] fin);
    @(negedge clk);
    func = f; OP0 = a; OP1 = b; flag_en = fen; flag_in = fin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  f, fin;
    logic [15:0] a, b;
    logic        fen;

    rst = 1'b1; func = 4'h1; OP0 = 16'h1234; OP1 = 16'h1111; flag_en = 1'b1; flag_in = 4'hF;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 20'h0_0000);
    @(negedge clk) rst = 1'b0;

    drive(4'h1, 16'h8001, 16'h0001, 1'b1, 4'b0000); check("add_8001", {16'h8002, 4'b1000});
    drive(4'h2, 16'h000A, 16'h0005, 1'b1, 4'b0000); check("sub_pos",  {16'h0005, 4'b0000});
    drive(4'h2, 16'h0005, 16'h000A, 1'b1, 4'b0000); check("sub_neg",  {16'hFFFB, 4'b1010});
    drive(4'h3, 16'h0001, 16'h0004, 1'b1, 4'b0000); check("lsl_4",    {16'h0010, 4'b0000});
    drive(4'h4, 16'h0001, 16'h0001, 1'b1, 4'b0000); check("lsr_1",    {16'h0000, 4'b0110});
    drive(4'h3, 16'h0001, 16'h0014, 1'b1, 4'b0000); check("lsl_big",  {16'h0000, 4'b0100});
    drive(4'h3, 16'hABCD, 16'h0000, 1'b1, 4'b0000); check("lsl_0",    {16'hABCD, 4'b1000});
    drive(4'h4, 16'h8000, 16'h000F, 1'b1, 4'b0000); check("lsr_15",   {16'h0001, 4'b0000});
    drive(4'hB, 16'h1234, 16'h5678, 1'b1, 4'b0100); check("beq",      {16'h0001, 4'b0100});
    drive(4'hC, 16'h1234, 16'h5678, 1'b1, 4'b0100); check("bne",      {16'h0000, 4'b0100});
    drive(4'h1, 16'h0001, 16'h0001, 1'b0, 4'b0101); check("add_noen", {16'h0002, 4'b0101});
    drive(4'hF, 16'h0001, 16'h1001, 1'b1, 4'b0000); check("cmp",      {16'hF000, 4'b1010});

    for (int i = 0; i < 300; i++) begin
      f   = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      fen = 1'($urandom_range(0, 1));
      fin = 4'($urandom);
      drive(f, a, b, fen, fin);
      check($sformatf("rand_%0d_f%0h", i, f), ref_model(int'(f), int'(a), int'(b), fen, fin));
    end

    // Reset asserted between edges clears outputs at once and discards the pending result.
    drive(4'h7, 16'hFFFF, 16'h0F0F, 1'b1, 4'b0000); check("pre_reset", {16'hF0F0, 4'b1000});
    @(negedge clk);
    func = 4'h1; OP0 = 16'h4000; OP1 = 16'h4000;
    #1 rst = 1'b1;
    #1 check("async_reset", 20'h0_0000);
    @(posedge clk);
    #1 check("reset_hold", 20'h0_0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("post_reset", {16'h8000, 4'b1001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
